// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared widths, response codes and FSM state types for the AXI-style slave memory.
package axi_lite_pkg;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 4;
  localparam int RO_ADDR = 7;
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;
  typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/axi_slave_regfile.sv
// axi_slave_regfile: 2**ADDR_W x DATA_W storage plus committed-write counter.
//   clk/reset_n : clock, async active-low reset (clears storage and counter)
//   we/waddr/wdata : write port; each accepted write also bumps the counter
//   raddr/rdata : combinational read port, RO_ADDR returns the counter
module axi_slave_regfile #(
  parameter int ADDR_W  = axi_lite_pkg::ADDR_W,
  parameter int DATA_W  = axi_lite_pkg::DATA_W,
  parameter int RO_ADDR = axi_lite_pkg::RO_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import axi_lite_pkg::*;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] mem_d [2**ADDR_W];
  logic [DATA_W-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (we && waddr != ADDR_W'(RO_ADDR)) mem_d[waddr] = wdata;
    cnt_d = we ? cnt_q + DATA_W'(1) : cnt_q;
    rdata = (raddr == ADDR_W'(RO_ADDR)) ? cnt_q : mem_q[raddr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem: single-beat AXI-style slave over a small register file with a write-count status entry.
//   wa_*/wd_*/b_* : write address, write data, write response channels
//   ra_*/rd_*     : read address, read data channels
//   clk/reset_n   : clock, async active-low reset
module axi_lite_slave_mem #(
  parameter int ADDR_W  = axi_lite_pkg::ADDR_W,
  parameter int DATA_W  = axi_lite_pkg::DATA_W,
  parameter int RO_ADDR = axi_lite_pkg::RO_ADDR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wa_valid,
  input  logic [ADDR_W-1:0] wa_addr,
  output logic              wa_ready,
  input  logic              wd_valid,
  input  logic [DATA_W-1:0] wd_data,
  input  logic              wd_strb,
  output logic              wd_ready,
  output logic              b_valid,
  output logic              b_response,
  input  logic              b_ready,
  input  logic              ra_valid,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic              ra_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);
  import axi_lite_pkg::*;
  logic rdy_q, rdy_d;
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic strb_q, strb_d;
  logic b_resp_q, b_resp_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] rf_rdata;
  logic aw_hs, wd_hs, ra_hs, commit, we;
  // Readies come only from registered state; rdy_q holds them low until one edge after reset release.
  assign wa_ready   = rdy_q && (wr_q == W_IDLE || wr_q == W_GOT_DATA);
  assign wd_ready   = rdy_q && (wr_q == W_IDLE || wr_q == W_GOT_ADDR);
  assign ra_ready   = rdy_q && rd_q == R_IDLE;
  assign b_valid    = wr_q == W_RESP;
  assign b_response = b_resp_q;
  assign rd_valid   = rd_q == R_DATA;
  assign rd_data    = rd_data_q;
  always_comb begin
    rdy_d  = 1'b1;
    aw_hs  = wa_valid && wa_ready;
    wd_hs  = wd_valid && wd_ready;
    ra_hs  = ra_valid && ra_ready;
    commit = (wr_q == W_IDLE && aw_hs && wd_hs) || (wr_q == W_GOT_ADDR && wd_hs) ||
             (wr_q == W_GOT_DATA && aw_hs);
    // The _d values merge a live handshake with whatever half was captured earlier.
    addr_d = aw_hs ? wa_addr : addr_q;
    data_d = wd_hs ? wd_data : data_q;
    strb_d = wd_hs ? wd_strb : strb_q;
    we     = commit && strb_d && addr_d != ADDR_W'(RO_ADDR);
    b_resp_d = commit ? ((addr_d == ADDR_W'(RO_ADDR)) ? RESP_SLVERR : RESP_OKAY) : b_resp_q;
    wr_d = commit ? W_RESP :
           (wr_q == W_RESP && b_ready) ? W_IDLE :
           (wr_q == W_IDLE && aw_hs) ? W_GOT_ADDR :
           (wr_q == W_IDLE && wd_hs) ? W_GOT_DATA : wr_q;
    rd_d = ra_hs ? R_DATA : (rd_q == R_DATA && rd_ready) ? R_IDLE : rd_q;
    // Read port sees pre-edge storage, so a same-edge write to the same address is not visible.
    rd_data_d = ra_hs ? rf_rdata : rd_data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b0;
      wr_q      <= W_IDLE;
      rd_q      <= R_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      rd_data_q <= '0;
    end else begin
      rdy_q     <= rdy_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      b_resp_q  <= b_resp_d;
      rd_data_q <= rd_data_d;
    end
  end
  axi_slave_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RO_ADDR(RO_ADDR)) u_rf (
    .clk(clk),
    .reset_n(reset_n),
    .we(we),
    .waddr(addr_d),
    .wdata(data_d),
    .raddr(ra_addr),
    .rdata(rf_rdata)
  );
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb_axi_lite_slave_mem: directed self-checking bench for axi_lite_slave_mem.
module tb_axi_lite_slave_mem;
  logic clk = 1'b0, reset_n = 1'b0;
  logic wa_valid = 0, wd_valid = 0, wd_strb = 0, b_ready = 1, ra_valid = 0, rd_ready = 1;
  logic [2:0] wa_addr = '0, ra_addr = '0;
  logic [3:0] wd_data = '0;
  logic wa_ready, wd_ready, b_valid, b_response, ra_ready, rd_valid;
  logic [3:0] rd_data;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  axi_lite_slave_mem dut (
    .clk(clk), .reset_n(reset_n),
    .wa_valid(wa_valid), .wa_addr(wa_addr), .wa_ready(wa_ready),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_strb(wd_strb), .wd_ready(wd_ready),
    .b_valid(b_valid), .b_response(b_response), .b_ready(b_ready),
    .ra_valid(ra_valid), .ra_addr(ra_addr), .ra_ready(ra_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic s, input logic er);
    int n = 0;
    @(negedge clk);
    wa_valid = 1; wa_addr = a; wd_valid = 1; wd_data = d; wd_strb = s;
    while (!(wa_ready && wd_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("wr_timeout", 32'(n), 0);
    @(negedge clk);
    wa_valid = 0; wd_valid = 0;
    check("b_valid", b_valid, 1);
    check("b_response", b_response, er);
  endtask
  task automatic rd(input logic [2:0] a, input logic [3:0] exp);
    int n = 0;
    @(negedge clk);
    ra_valid = 1; ra_addr = a;
    while (!ra_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rd_timeout", 32'(n), 0);
    @(negedge clk);
    ra_valid = 0;
    check("rd_valid", rd_valid, 1);
    check($sformatf("rd_data@%0d", a), rd_data, exp);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_wa_ready", wa_ready, 0);
    check("rst_wd_ready", wd_ready, 0);
    check("rst_ra_ready", ra_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_response", b_response, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    reset_n = 1;
    #1 check("ready_before_edge", wa_ready, 0);
    @(negedge clk);
    check("ready_after_edge", {wa_ready, wd_ready, ra_ready}, 3'b111);
    wr(3'd2, 4'hA, 1, 0);
    @(negedge clk);
    check("b_valid_one_cycle", b_valid, 0);
    rd(3'd2, 4'hA);
    @(negedge clk);
    wd_valid = 1; wd_data = 4'h5; wd_strb = 1;
    @(negedge clk);
    wd_valid = 0;
    check("data_first_wd_ready", wd_ready, 0);
    check("data_first_wa_ready", wa_ready, 1);
    check("data_first_b_valid", b_valid, 0);
    @(negedge clk);
    wa_valid = 1; wa_addr = 3'd3;
    @(negedge clk);
    wa_valid = 0;
    check("late_addr_b_valid", b_valid, 1);
    check("late_addr_b_response", b_response, 0);
    rd(3'd3, 4'h5);
    wr(3'd7, 4'h3, 1, 1);
    rd(3'd7, 4'h2);
    wr(3'd1, 4'hF, 0, 0);
    rd(3'd1, 4'h0);
    rd(3'd7, 4'h2);
    b_ready = 0;
    wr(3'd4, 4'h6, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_b_valid", b_valid, 1);
      check("hold_b_response", b_response, 0);
      check("hold_w_readies", {wa_ready, wd_ready}, 2'b00);
    end
    b_ready = 1;
    @(negedge clk);
    check("b_release", b_valid, 0);
    rd_ready = 0;
    rd(3'd4, 4'h6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rd_valid", rd_valid, 1);
      check("hold_rd_data", rd_data, 4'h6);
      check("hold_ra_ready", ra_ready, 0);
    end
    rd_ready = 1;
    @(negedge clk);
    check("rd_release", rd_valid, 0);
    @(negedge clk);
    wa_valid = 1; wa_addr = 3'd2; wd_valid = 1; wd_data = 4'h9; wd_strb = 1;
    ra_valid = 1; ra_addr = 3'd2;
    @(negedge clk);
    wa_valid = 0; wd_valid = 0; ra_valid = 0;
    check("same_edge_b_valid", b_valid, 1);
    check("same_edge_rd_valid", rd_valid, 1);
    check("same_edge_old_data", rd_data, 4'hA);
    rd(3'd2, 4'h9);
    rd(3'd7, 4'h4);
    for (int i = 0; i < 13; i++) wr(3'(i % 7), 4'(i), 1, 0);
    rd(3'd7, 4'h1);
    b_ready = 0;
    wr(3'd5, 4'h3, 1, 0);
    #2 reset_n = 0;
    #1 check("reset_drops_b_valid", b_valid, 0);
    check("reset_drops_readies", {wa_ready, wd_ready, ra_ready}, 3'b000);
    b_ready = 1;
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 8; i++) rd(3'(i), 4'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
